// File: rtl/uart_frame_parser.sv
// Command-frame parser behind a UART RX FIFO: SOF, CMD, LEN, payload, XOR checksum.
// Optional FRAME_STATS_EN adds saturating frame-ok / frame-error counters.
module uart_frame_parser #(
   parameter int unsigned MAX_PAYLOAD    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 200_000,
   parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_rd_en,
   output logic [7:0]  o_cmd,
   output logic [7:0]  o_len,
   output logic [7:0]  o_pl_data,
   output logic        o_pl_valid,
   output logic        o_pl_last,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic        o_busy
`ifdef FRAME_STATS_EN
   ,
   output logic [15:0] o_ok_cnt,
   output logic [15:0] o_err_cnt
`endif
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   // Error is registered, so firing at TIMEOUT_CYCLES-2 lands the pulse TIMEOUT_CYCLES
   // cycles after the last consume cycle.
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {StHunt, StCmd, StLen, StPayload, StChk} state_t;

   state_t        state_q, state_d;
   logic          pend_q;
   logic [TW-1:0] idle_q, idle_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    chk_q, chk_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    pl_data_q, pl_data_d;
   logic          pl_valid_q, pl_valid_d;
   logic          pl_last_q, pl_last_d;
   logic          ok_q, ok_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;

   // At most one read in flight: pop, then consume on the following cycle.
   assign o_rx_rd_en = i_rx_valid & ~pend_q & ~rst;

   always_comb begin
      state_d    = state_q;
      idle_d     = idle_q;
      cnt_d      = cnt_q;
      chk_d      = chk_q;
      cmd_d      = cmd_q;
      len_d      = len_q;
      pl_data_d  = pl_data_q;
      pl_valid_d = 1'b0;
      pl_last_d  = 1'b0;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      code_d     = code_q;
      if (pend_q) begin
         idle_d = '0;
         case (state_q)
            StHunt: begin
               if (i_rx_data == SOF_BYTE) state_d = StCmd;
            end
            StCmd: begin
               cmd_d   = i_rx_data;
               chk_d   = i_rx_data;
               state_d = StLen;
            end
            StLen: begin
               len_d = i_rx_data;
               chk_d = chk_q ^ i_rx_data;
               if (32'(i_rx_data) > MAX_PAYLOAD) begin
                  err_d   = 1'b1;
                  code_d  = 2'b10;
                  state_d = StHunt;
               end else if (i_rx_data == 8'd0) begin
                  state_d = StChk;
               end else begin
                  cnt_d   = i_rx_data;
                  state_d = StPayload;
               end
            end
            StPayload: begin
               pl_data_d  = i_rx_data;
               pl_valid_d = 1'b1;
               chk_d      = chk_q ^ i_rx_data;
               cnt_d      = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  pl_last_d = 1'b1;
                  state_d   = StChk;
               end
            end
            StChk: begin
               if (i_rx_data == chk_q) begin
                  ok_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'b01;
               end
               state_d = StHunt;
            end
            default: state_d = StHunt;
         endcase
      end else if (state_q != StHunt) begin
         if (idle_q == IDLE_LIMIT) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = StHunt;
            idle_d  = '0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StHunt;
         pend_q     <= 1'b0;
         idle_q     <= '0;
         cnt_q      <= '0;
         chk_q      <= '0;
         cmd_q      <= '0;
         len_q      <= '0;
         pl_data_q  <= '0;
         pl_valid_q <= 1'b0;
         pl_last_q  <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= o_rx_rd_en;
         idle_q     <= idle_d;
         cnt_q      <= cnt_d;
         chk_q      <= chk_d;
         cmd_q      <= cmd_d;
         len_q      <= len_d;
         pl_data_q  <= pl_data_d;
         pl_valid_q <= pl_valid_d;
         pl_last_q  <= pl_last_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   assign o_cmd       = cmd_q;
   assign o_len       = len_q;
   assign o_pl_data   = pl_data_q;
   assign o_pl_valid  = pl_valid_q;
   assign o_pl_last   = pl_last_q;
   assign o_frame_ok  = ok_q;
   assign o_frame_err = err_q;
   assign o_err_code  = code_q;
   assign o_busy      = (state_q != StHunt);

`ifdef FRAME_STATS_EN
   logic [15:0] ok_cnt_q, err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ok_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         if (ok_q && ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
         if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign o_ok_cnt  = ok_cnt_q;
   assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: FIFO model feeds bytes, expected events are
// queued as frames are built and compared when the DUT emits them.
module tb_uart_frame_parser;

   localparam int unsigned MAXP = 16;
   localparam int unsigned TMO  = 100;
   localparam int KPL  = 0;
   localparam int KOK  = 1;
   localparam int KERR = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_rx_valid = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       o_rx_rd_en, o_pl_valid, o_pl_last, o_frame_ok, o_frame_err, o_busy;
   logic [7:0] o_cmd, o_len, o_pl_data;
   logic [1:0] o_err_code;
`ifdef FRAME_STATS_EN
   logic [15:0] o_ok_cnt, o_err_cnt;
`endif

   always #5 clk = ~clk;

   uart_frame_parser #(
      .MAX_PAYLOAD    (MAXP),
      .TIMEOUT_CYCLES (TMO),
      .SOF_BYTE       (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_valid  (i_rx_valid),
      .i_rx_data   (i_rx_data),
      .o_rx_rd_en  (o_rx_rd_en),
      .o_cmd       (o_cmd),
      .o_len       (o_len),
      .o_pl_data   (o_pl_data),
      .o_pl_valid  (o_pl_valid),
      .o_pl_last   (o_pl_last),
      .o_frame_ok  (o_frame_ok),
      .o_frame_err (o_frame_err),
      .o_err_code  (o_err_code),
      .o_busy      (o_busy)
`ifdef FRAME_STATS_EN
      ,
      .o_ok_cnt    (o_ok_cnt),
      .o_err_cnt   (o_err_cnt)
`endif
   );

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       last;
      logic [1:0] code;
      int         dly;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] rx_fifo[$];
   logic [7:0] pl_buf[$];
   int         n_vec = 0;
   int         n_miss = 0;
   int         cyc = 0;
   int         last_cons = 0;
   logic       busy_at_err = 1'b1;

   // Monitor runs before the FIFO model so last_cons still refers to the prior consume.
   always @(negedge clk) begin : mon_fifo
      ev_t e;
      int  kind;
      cyc++;
      if (o_pl_valid || o_frame_ok || o_frame_err) begin
         n_vec++;
         kind = o_pl_valid ? KPL : (o_frame_ok ? KOK : KERR);
         if (int'(o_pl_valid) + int'(o_frame_ok) + int'(o_frame_err) > 1) begin
            n_miss++;
            $display("FAIL exclusive: pl=%b ok=%b err=%b, want one-hot", o_pl_valid, o_frame_ok,
                     o_frame_err);
         end else if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected: kind=%0d data=%h code=%b at cycle %0d, want none", kind,
                     o_pl_data, o_err_code, cyc);
         end else begin
            e = exp_q.pop_front();
            if (kind !== e.kind
                || (kind == KPL && {o_pl_data, o_pl_last} !== {e.data, e.last})
                || (kind == KERR && o_err_code !== e.code)
                || (kind != KPL && (cyc - last_cons) !== e.dly)) begin
               n_miss++;
               $display("FAIL event: got kind=%0d data=%h last=%b code=%b dly=%0d, want kind=%0d data=%h last=%b code=%b dly=%0d",
                        kind, o_pl_data, o_pl_last, o_err_code, cyc - last_cons, e.kind, e.data,
                        e.last, e.code, e.dly);
            end
         end
         if (o_frame_err) busy_at_err = o_busy;
      end
      if (o_rx_rd_en) begin
         if (rx_fifo.size() != 0) i_rx_data = rx_fifo.pop_front();
         last_cons = cyc + 1;
      end else begin
         i_rx_valid = (rx_fifo.size() != 0);
      end
   end

   task automatic exp_ev(input int k, input logic [7:0] d, input logic l, input logic [1:0] c,
                         input int dl);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.last = l;
      e.code = c;
      e.dly  = dl;
      exp_q.push_back(e);
   endtask

   // Builds SOF CMD LEN payload CHK from pl_buf and queues the expected events.
   task automatic send_frame(input logic [7:0] cmd, input bit bad);
      logic [7:0] chk;
      logic [7:0] len;
      len = 8'(pl_buf.size());
      chk = cmd ^ len;
      rx_fifo.push_back(8'hA5);
      rx_fifo.push_back(cmd);
      rx_fifo.push_back(len);
      for (int i = 0; i < pl_buf.size(); i++) begin
         rx_fifo.push_back(pl_buf[i]);
         exp_ev(KPL, pl_buf[i], (i == pl_buf.size() - 1), 2'b00, 0);
         chk = chk ^ pl_buf[i];
      end
      rx_fifo.push_back(bad ? (chk ^ 8'h03) : chk);
      if (bad) exp_ev(KERR, 8'h00, 1'b0, 2'b01, 1);
      else     exp_ev(KOK, 8'h00, 1'b0, 2'b00, 1);
   endtask

   task automatic drain(input bit need_idle, input int budget, output bit done);
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rx_fifo.size() == 0 && exp_q.size() == 0 && (!need_idle || !o_busy)) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         exp_q.delete();
         rx_fifo.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({o_rx_rd_en, o_cmd, o_len, o_pl_data, o_pl_valid, o_pl_last, o_frame_ok, o_frame_err,
           o_err_code, o_busy} !== 32'h0) begin
         n_miss++;
         $display("FAIL reset_state: cmd=%h len=%h busy=%b err=%b code=%b, want all 0", o_cmd,
                  o_len, o_busy, o_frame_err, o_err_code);
      end
   endtask

   task automatic test_good();
      bit done;
      pl_buf = '{8'h33, 8'h44};
      send_frame(8'h10, 1'b0);
      drain(1'b1, 200, done);
      n_vec++;
      if ({done, o_cmd, o_len} !== {1'b1, 8'h10, 8'h02}) begin
         n_miss++;
         $display("FAIL good_frame: done=%b cmd=%h len=%h, want 1 10 02", done, o_cmd, o_len);
      end
   endtask

   task automatic test_bad_chk();
      bit done;
      pl_buf = '{8'h33, 8'h44};
      send_frame(8'h10, 1'b1);
      drain(1'b1, 200, done);
      repeat (3) @(negedge clk);
      n_vec++;
      if ({done, o_err_code} !== {1'b1, 2'b01}) begin
         n_miss++;
         $display("FAIL bad_chk: done=%b held code=%b, want 1 01", done, o_err_code);
      end
   endtask

   task automatic test_garbage();
      bit done;
      rx_fifo.push_back(8'h00);
      rx_fifo.push_back(8'hFF);
      rx_fifo.push_back(8'h5A);
      pl_buf.delete();
      send_frame(8'h07, 1'b0);
      drain(1'b1, 200, done);
      n_vec++;
      if ({done, o_cmd, o_len} !== {1'b1, 8'h07, 8'h00}) begin
         n_miss++;
         $display("FAIL garbage_then_good: done=%b cmd=%h len=%h, want 1 07 00", done, o_cmd,
                  o_len);
      end
   endtask

   task automatic test_len_err();
      bit done;
      rx_fifo.push_back(8'hA5);
      rx_fifo.push_back(8'h01);
      rx_fifo.push_back(8'h11);
      exp_ev(KERR, 8'h00, 1'b0, 2'b10, 1);
      pl_buf.delete();
      send_frame(8'h01, 1'b0);
      drain(1'b1, 200, done);
      n_vec++;
      if ({done, o_cmd, o_len, o_err_code} !== {1'b1, 8'h01, 8'h00, 2'b10}) begin
         n_miss++;
         $display("FAIL len_err: done=%b cmd=%h len=%h code=%b, want 1 01 00 10", done, o_cmd,
                  o_len, o_err_code);
      end
   endtask

   task automatic test_max_len();
      bit done;
      pl_buf.delete();
      for (int i = 0; i < MAXP; i++) pl_buf.push_back(8'($urandom));
      send_frame(8'h3C, 1'b0);
      drain(1'b1, 400, done);
      n_vec++;
      if ({done, o_len} !== {1'b1, 8'(MAXP)}) begin
         n_miss++;
         $display("FAIL max_len: done=%b len=%h, want 1 %h", done, o_len, 8'(MAXP));
      end
   endtask

   task automatic test_timeout();
      bit done;
      busy_at_err = 1'b1;
      rx_fifo.push_back(8'hA5);
      rx_fifo.push_back(8'h10);
      exp_ev(KERR, 8'h00, 1'b0, 2'b11, int'(TMO));
      drain(1'b1, 400, done);
      n_vec++;
      if ({done, busy_at_err, o_busy} !== 3'b100) begin
         n_miss++;
         $display("FAIL timeout: done=%b busy_at_err=%b busy=%b, want 1 0 0", done, busy_at_err,
                  o_busy);
      end
   endtask

   task automatic test_reset_mid();
      bit done;
      rx_fifo.push_back(8'hA5);
      rx_fifo.push_back(8'h20);
      rx_fifo.push_back(8'h04);
      rx_fifo.push_back(8'h01);
      rx_fifo.push_back(8'h02);
      exp_ev(KPL, 8'h01, 1'b0, 2'b00, 0);
      exp_ev(KPL, 8'h02, 1'b0, 2'b00, 0);
      drain(1'b0, 200, done);
      repeat (2) @(negedge clk);
      n_vec++;
      if ({done, o_busy} !== 2'b11) begin
         n_miss++;
         $display("FAIL mid_payload: done=%b busy=%b, want 1 1", done, o_busy);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({o_rx_rd_en, o_cmd, o_len, o_pl_data, o_pl_valid, o_pl_last, o_frame_ok, o_frame_err,
           o_err_code, o_busy} !== 32'h0) begin
         n_miss++;
         $display("FAIL reset_mid: cmd=%h len=%h data=%h busy=%b code=%b, want all 0", o_cmd,
                  o_len, o_pl_data, o_busy, o_err_code);
      end
      repeat (TMO + 50) @(negedge clk);
      pl_buf.delete();
      send_frame(8'h01, 1'b0);
      drain(1'b1, 200, done);
      n_vec++;
      if (done !== 1'b1) begin
         n_miss++;
         $display("FAIL after_reset_frame: done=%b, want 1", done);
      end
   endtask

   task automatic test_back_to_back();
      bit done;
      int n;
      for (int f = 0; f < 6; f++) begin
         pl_buf.delete();
         n = $urandom_range(0, MAXP);
         for (int i = 0; i < n; i++) pl_buf.push_back(8'($urandom));
         send_frame(8'($urandom), ($urandom_range(0, 2) == 0));
      end
      drain(1'b1, 3000, done);
      n_vec++;
      if (done !== 1'b1) begin
         n_miss++;
         $display("FAIL back_to_back: done=%b, want 1", done);
      end
   endtask

`ifdef FRAME_STATS_EN
   task automatic test_stats();
      bit done;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pl_buf = '{8'h12, 8'h34, 8'h56};
      for (int f = 0; f < 5; f++) send_frame(8'(f), (f >= 3));
      drain(1'b1, 1000, done);
      repeat (3) @(negedge clk);
      n_vec++;
      if ({done, o_ok_cnt, o_err_cnt} !== {1'b1, 16'd3, 16'd2}) begin
         n_miss++;
         $display("FAIL stats_count: done=%b ok=%0d err=%0d, want 1 3 2", done, o_ok_cnt,
                  o_err_cnt);
      end
      force dut.ok_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.ok_cnt_q;
      send_frame(8'h55, 1'b0);
      drain(1'b1, 200, done);
      repeat (3) @(negedge clk);
      n_vec++;
      if ({done, o_ok_cnt} !== {1'b1, 16'hFFFF}) begin
         n_miss++;
         $display("FAIL stats_saturate: done=%b ok=%h, want 1 FFFF", done, o_ok_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_good();
      test_bad_chk();
      test_garbage();
      test_len_err();
      test_max_len();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
`ifdef FRAME_STATS_EN
      test_stats();
`endif
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receive path. Pops bytes from the UART RX FIFO read port.
- Parses command frames of the form SOF(0xA5), CMD, LEN, LEN payload bytes, CHK.
- Streams payload bytes to the system and ends every frame with either a frame-OK pulse or a frame-error pulse plus an error code.
- The system consumer must discard the payload of any errored frame.

Parameters:
- MAX_PAYLOAD, 16, largest accepted LEN value (1..255).
- TIMEOUT_CYCLES, 200_000, idle clock cycles allowed between bytes mid-frame before abort (≥2).
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_rx_valid  in  1  RX FIFO non-empty
- i_rx_data  in  8  RX FIFO read data; valid the cycle after o_rx_rd_en
- o_rx_rd_en  out  1  RX FIFO pop request, single-cycle pulse
- o_cmd  out  8  CMD byte of current frame; held until next frame's CMD
- o_len  out  8  LEN byte of current frame; held until next frame's LEN
- o_pl_data  out  8  payload byte
- o_pl_valid  out  1  o_pl_data valid, one-cycle pulse per byte
- o_pl_last  out  1  with o_pl_valid, marks final payload byte
- o_frame_ok  out  1  one-cycle pulse: checksum matched
- o_frame_err  out  1  one-cycle pulse: frame aborted
- o_err_code  out  2  with o_frame_err: 01 checksum, 10 LEN>MAX_PAYLOAD, 11 timeout; held until next error
- o_busy  out  1  high when state ≠ HUNT

Behaviour:
- Reset: clock is clk; reset rst is asynchronous and active-high. All outputs reset to 0, state goes to HUNT, counters and checksum clear. Reset mid-frame drops the frame with no error pulse. A byte already popped is lost.
- Fetch handshake:
  - When i_rx_valid=1 and no read is outstanding, assert o_rx_rd_en for 1 cycle.
  - The next cycle is the consume cycle: i_rx_data is taken by the FSM, and o_rx_rd_en stays 0.
  - Maximum throughput is 1 byte per 2 cycles.
- FSM states: HUNT, CMD, LEN, PAYLOAD, CHK.
  - HUNT: a consumed byte equal to SOF_BYTE goes to CMD. Any other byte is dropped silently.
  - CMD: latch o_cmd and set chk = byte; go to LEN.
  - LEN: latch o_len and set chk ^= byte.
    - LEN > MAX_PAYLOAD: o_frame_err with code 10, go to HUNT.
    - LEN = 0: go to CHK.
    - Otherwise: load remaining count = LEN and go to PAYLOAD.
  - PAYLOAD: each consumed byte drives o_pl_data and o_pl_valid on the cycle after consume, sets chk ^= byte, and decrements the count. o_pl_last=1 when the count was 1; that byte also moves the FSM to CHK.
  - CHK: byte == chk gives o_frame_ok; otherwise o_frame_err with code 01. Either way go to HUNT.
- Output timing: o_frame_ok and o_frame_err assert on the cycle after the CHK byte is consumed. Both are registered.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes. SOF_BYTE is excluded.
- Timeout:
  - An idle counter runs in every state except HUNT and clears on each consumed byte.
  - Reaching TIMEOUT_CYCLES gives o_frame_err with code 11, goes to HUNT and clears the counter.
  - A byte consumed in the same cycle the counter would expire takes priority; no timeout is raised.
  - An outstanding read completes normally. In HUNT that byte is treated as a hunt candidate.
- Counter width: $clog2(TIMEOUT_CYCLES+1).
- Exclusivity: o_frame_ok and o_frame_err are never high together. o_pl_valid never coincides with either.

Optional Feature:
- Macro: FRAME_STATS_EN.
- When defined, adds ports o_ok_cnt (out, 16) and o_err_cnt (out, 16):
  - o_ok_cnt increments on each o_frame_ok pulse.
  - o_err_cnt increments on each o_frame_err pulse.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Good frame A5 10 02 33 44 65 → o_cmd=10, o_len=02; o_pl_valid twice with data 33 then 44; o_pl_last on 44; one o_frame_ok pulse; no o_frame_err.
- Same frame with CHK=66 → payload 33, 44 still streamed; o_frame_err with o_err_code=01; no o_frame_ok.
- Garbage 00 FF 5A, then good frame A5 07 00 07 → first three bytes dropped; o_frame_ok; zero o_pl_valid pulses; o_len=00.
- MAX_PAYLOAD=16, bytes A5 01 11 → o_frame_err with code 10 one cycle after LEN consumed. A following A5 01 00 01 gives o_frame_ok.
- TIMEOUT_CYCLES=100, bytes A5 10 then FIFO empty → o_frame_err with code 11 exactly 100 cycles after the 10 byte is consumed; o_busy drops to 0 the same cycle. Also assert rst mid-PAYLOAD: all outputs 0, no error pulse, FSM back in HUNT.
- FRAME_STATS_EN defined: 3 good frames and 2 bad-checksum frames → o_ok_cnt=3, o_err_cnt=2. Preload the counter to FFFF via force: one more ok pulse leaves o_ok_cnt at FFFF.
